// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog; div_tick exists only with CLK_DIV_TICK_EN.
interface clock_divider_prog_if #(
  parameter int RATIO_W = 8
);
  logic               clk_divider_enable;
  logic [RATIO_W-1:0] division_ratio;
  logic               output_clk;
  logic               busy;
  logic               ratio_err;
  logic [RATIO_W-1:0] active_ratio;
`ifdef CLK_DIV_TICK_EN
  logic               div_tick;

  modport master (
    output clk_divider_enable, division_ratio,
    input  output_clk, busy, ratio_err, active_ratio, div_tick
  );
  modport slave (
    input  clk_divider_enable, division_ratio,
    output output_clk, busy, ratio_err, active_ratio, div_tick
  );
`else
  modport master (
    output clk_divider_enable, division_ratio,
    input  output_clk, busy, ratio_err, active_ratio
  );
  modport slave (
    input  clk_divider_enable, division_ratio,
    output output_clk, busy, ratio_err, active_ratio
  );
`endif
endinterface

// File: rtl/clock_divider_prog.sv
// Glitch-free programmable integer clock divider; ratio and enable changes apply at period boundaries.
// Optional CLK_DIV_TICK_EN adds a one-cycle div_tick coincident with each output_clk rise.
//
// state | meaning
// IDLE  | stopped, output_clk low
// HIGH  | high phase, cnt runs 1..N>>1
// LOW   | low phase, cnt runs 1..N-(N>>1); last cycle is the period boundary
module clock_divider_prog #(
  parameter int RATIO_W     = 8,
  parameter int RESET_RATIO = 2
) (
  input  logic                 reference_clk,
  input  logic                 reset,
  clock_divider_prog_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t             state_q, state_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               tick_d;
  logic [RATIO_W-1:0] high_len, low_len;
  logic               ratio_ok;

  assign high_len = ratio_q >> 1;
  assign low_len  = ratio_q - high_len;
  assign ratio_ok = bus.clk_divider_enable && (bus.division_ratio >= RATIO_W'(2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    err_d   = bus.clk_divider_enable && (bus.division_ratio < RATIO_W'(2));
    case (state_q)
      IDLE: begin
        out_d = 1'b0;
        if (ratio_ok) begin
          ratio_d = bus.division_ratio;
          state_d = HIGH;
          cnt_d   = RATIO_W'(1);
          out_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == high_len) begin
          state_d = LOW;
          out_d   = 1'b0;
          cnt_d   = RATIO_W'(1);
        end else begin
          cnt_d = cnt_q + RATIO_W'(1);
        end
      end
      LOW: begin
        if (cnt_q != low_len) begin
          cnt_d = cnt_q + RATIO_W'(1);
        end else if (ratio_ok) begin
          ratio_d = bus.division_ratio;
          state_d = HIGH;
          cnt_d   = RATIO_W'(1);
          out_d   = 1'b1;
          tick_d  = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge reference_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ratio_q <= RATIO_W'(RESET_RATIO);
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.output_clk   = out_q;
  assign bus.busy         = busy_q;
  assign bus.ratio_err    = err_q;
  assign bus.active_ratio = ratio_q;

`ifdef CLK_DIV_TICK_EN
  logic tick_q;
  always_ff @(posedge reference_clk) begin
    if (!reset) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end
  assign bus.div_tick = tick_q;
`else
  logic unused_tick;
  assign unused_tick = tick_d;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: table of ratios plus hand-built corner sequences.
`timescale 1ps/1ps
module tb_clock_divider_prog;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #20 clk = ~clk;

  clock_divider_prog_if #(.RATIO_W(W)) bus ();

  clock_divider_prog #(.RATIO_W(W), .RESET_RATIO(2)) u_dut (
    .reference_clk (clk),
    .reset         (rst),
    .bus           (bus)
  );

  typedef struct {
    logic         o;
    logic         b;
    logic         e;
    logic         t;
    logic [W-1:0] a;
  } exp_t;

  typedef struct {
    logic [W-1:0] ratio;
    int           hi;
    int           lo;
    int           periods;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push_item(input logic o, input logic b, input logic e, input logic t,
                           input logic [W-1:0] a);
    exp_t x;
    x.o = o; x.b = b; x.e = e; x.t = t; x.a = a;
    sb.push_back(x);
  endtask

  task automatic push_period(input int hi, input int lo, input logic [W-1:0] a);
    for (int i = 0; i < hi; i++) push_item(1'b1, 1'b1, 1'b0, (i == 0), a);
    for (int i = 0; i < lo; i++) push_item(1'b0, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic check_n(input int n, input string name);
    exp_t x;
    logic t_got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
      end else begin
        x = sb.pop_front();
`ifdef CLK_DIV_TICK_EN
        t_got = bus.div_tick;
`else
        t_got = x.t;
`endif
        if (bus.output_clk !== x.o || bus.busy !== x.b || bus.ratio_err !== x.e ||
            bus.active_ratio !== x.a || t_got !== x.t) begin
          errors++;
          $display("FAIL %s t=%0t: got clk=%b busy=%b err=%b tick=%b ratio=%0d, need clk=%b busy=%b err=%b tick=%b ratio=%0d",
                   name, $time, bus.output_clk, bus.busy, bus.ratio_err, t_got, bus.active_ratio,
                   x.o, x.b, x.e, x.t, x.a);
        end
      end
    end
  endtask

  vec_t vecs[6];
  logic [W-1:0] last;

  initial begin
    vecs[0] = '{ratio: 8'd5,   hi: 2,   lo: 3,   periods: 3};
    vecs[1] = '{ratio: 8'd8,   hi: 4,   lo: 4,   periods: 2};
    vecs[2] = '{ratio: 8'd2,   hi: 1,   lo: 1,   periods: 3};
    vecs[3] = '{ratio: 8'd3,   hi: 1,   lo: 2,   periods: 2};
    vecs[4] = '{ratio: 8'd4,   hi: 2,   lo: 2,   periods: 3};
    vecs[5] = '{ratio: 8'd255, hi: 127, lo: 128, periods: 2};

    // reset hold with a valid request pending
    rst = 1'b0;
    bus.clk_divider_enable = 1'b1;
    bus.division_ratio     = 8'd5;
    for (int i = 0; i < 3; i++) push_item(1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    check_n(3, "reset_hold");
    rst = 1'b1;
    bus.clk_divider_enable = 1'b0;
    push_item(1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    check_n(1, "post_reset_idle");

    foreach (vecs[k]) begin
      bus.clk_divider_enable = 1'b1;
      bus.division_ratio     = vecs[k].ratio;
      for (int p = 0; p < vecs[k].periods; p++) push_period(vecs[k].hi, vecs[k].lo, vecs[k].ratio);
      check_n(vecs[k].periods * (vecs[k].hi + vecs[k].lo), "vector_run");
      bus.clk_divider_enable = 1'b0;
      push_item(1'b0, 1'b0, 1'b0, 1'b0, vecs[k].ratio);
      check_n(1, "vector_idle");
    end
    last = 8'd255;

    // ratio 5 -> 3 during the second high cycle
    bus.clk_divider_enable = 1'b1;
    bus.division_ratio     = 8'd5;
    push_period(2, 3, 8'd5);
    push_period(1, 2, 8'd3);
    push_item(1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    check_n(2, "boundary_old");
    bus.division_ratio = 8'd3;
    check_n(6, "boundary_new");
    bus.clk_divider_enable = 1'b0;
    check_n(1, "boundary_idle");

    // disable in high cycle 1, then re-enable
    bus.clk_divider_enable = 1'b1;
    bus.division_ratio     = 8'd6;
    push_period(3, 3, 8'd6);
    push_item(1'b0, 1'b0, 1'b0, 1'b0, 8'd6);
    check_n(1, "disable_first");
    bus.clk_divider_enable = 1'b0;
    check_n(6, "disable_finish");
    bus.clk_divider_enable = 1'b1;
    push_period(3, 3, 8'd6);
    check_n(6, "reenable");
    bus.clk_divider_enable = 1'b0;
    push_item(1'b0, 1'b0, 1'b0, 1'b0, 8'd6);
    check_n(1, "reenable_idle");
    last = 8'd6;

    // invalid ratios: flagged, never loaded, no output
    bus.clk_divider_enable = 1'b1;
    bus.division_ratio     = 8'd1;
    for (int i = 0; i < 3; i++) push_item(1'b0, 1'b0, 1'b1, 1'b0, last);
    check_n(3, "ratio_one");
    bus.division_ratio = 8'd0;
    for (int i = 0; i < 2; i++) push_item(1'b0, 1'b0, 1'b1, 1'b0, last);
    check_n(2, "ratio_zero");
    bus.clk_divider_enable = 1'b0;
    push_item(1'b0, 1'b0, 1'b0, 1'b0, last);
    check_n(1, "ratio_err_clear");

    // invalid ratio at a period boundary acts as disable
    bus.clk_divider_enable = 1'b1;
    bus.division_ratio     = 8'd4;
    push_period(2, 2, 8'd4);
    push_item(1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    check_n(1, "bad_boundary_start");
    bus.division_ratio = 8'd1;
    push_item(1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    for (int i = 0; i < 3; i++) sb[i].e = 1'b1;
    check_n(5, "bad_boundary");
    bus.clk_divider_enable = 1'b0;
    push_item(1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
    check_n(1, "bad_boundary_idle");

    // reset during a high phase
    bus.clk_divider_enable = 1'b1;
    bus.division_ratio     = 8'd6;
    push_item(1'b1, 1'b1, 1'b0, 1'b1, 8'd6);
    push_item(1'b1, 1'b1, 1'b0, 1'b0, 8'd6);
    check_n(2, "pre_reset_high");
    rst = 1'b0;
    bus.clk_divider_enable = 1'b0;
    push_item(1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    check_n(1, "reset_mid_high");
    rst = 1'b1;
    push_item(1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    check_n(1, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
